// File: rtl/invader_fleet_controller_if.sv
// Bundles the fleet controller's frame/collision inputs and its formation/status outputs.
// The master side is the game logic and the slave side is the controller.
interface invader_fleet_controller_if;
    logic       frame;
    logic [5:0] invader_collision;
    logic       restart;
    logic [9:0] invaders_x;
    logic [9:0] invaders_y;
    logic [5:0] alive;
    logic       kill;
    logic [2:0] kill_num;
    logic       step;
    logic       anim;
    logic       cleared;
    logic       landed;

    modport master (
        output frame, invader_collision, restart,
        input  invaders_x, invaders_y, alive, kill, kill_num, step, anim, cleared, landed
    );

    modport slave (
        input  frame, invader_collision, restart,
        output invaders_x, invaders_y, alive, kill, kill_num, step, anim, cleared, landed
    );
endinterface

// File: rtl/invader_fleet_controller.sv
// Marches a single row of six invaders, descends at the screen edges and speeds up per kill.
// state     | meaning
// MARCH_R   | stepping right on each period expiry
// MARCH_L   | stepping left on each period expiry
// DONE_CLR  | every invader destroyed, waiting for restart
// DONE_LAND | fleet reached the bottom, waiting for restart
module invader_fleet_controller #(
    parameter int SCREEN_W    = 640,
    parameter int INVADER_W   = 32,
    parameter int PITCH       = 48,
    parameter int START_X     = 64,
    parameter int START_Y     = 48,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 16,
    parameter int BOTTOM_Y    = 400,
    parameter int BASE_PERIOD = 30,
    parameter int SPEEDUP     = 4,
    parameter int MIN_PERIOD  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    invader_fleet_controller_if.slave   bus
);

    typedef enum logic [1:0] {MARCH_R, MARCH_L, DONE_CLR, DONE_LAND} state_t;

    localparam logic signed [7:0] BASE_S  = 8'(BASE_PERIOD);
    localparam logic signed [7:0] SPEED_S = 8'(SPEEDUP);
    localparam logic signed [7:0] MIN_S   = 8'(MIN_PERIOD);

    state_t      state, state_nx;
    logic [7:0]  frame_cnt, frame_cnt_nx;
    logic [2:0]  kills, kills_nx;
    logic [9:0]  x_nx, y_nx;
    logic [5:0]  alive_nx;
    logic        kill_nx, step_nx, anim_nx, cleared_nx, landed_nx;
    logic [2:0]  kill_num_nx;

    logic signed [7:0] period_raw, period;
    logic        step_due;
    logic [5:0]  hits;
    logic [2:0]  hit_cnt;
    logic [2:0]  lm, rm;
    logic [10:0] left_edge, right_edge;
    logic        can_right, can_left;
    logic [9:0]  y_desc;
    logic        descend;

    function automatic logic [2:0] popcnt(input logic [5:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 6; i++) c = c + {2'b00, v[i]};
        return c;
    endfunction

    // Signed so that a large kill count clamps to MIN_PERIOD instead of wrapping.
    always_comb begin
        period_raw = BASE_S - SPEED_S * $signed({5'b00000, kills});
        period     = (period_raw < MIN_S) ? MIN_S : period_raw;
        step_due   = ({1'b0, frame_cnt} + 9'd1) >= {1'b0, period};
    end

    always_comb begin
        lm = '0;
        rm = '0;
        for (int i = 5; i >= 0; i--) if (bus.alive[i]) lm = 3'(i);
        for (int i = 0; i < 6; i++)  if (bus.alive[i]) rm = 3'(i);
    end

    assign hits       = bus.invader_collision & bus.alive;
    assign hit_cnt    = popcnt(hits);
    assign left_edge  = {1'b0, bus.invaders_x} + 11'(lm) * 11'(PITCH);
    assign right_edge = {1'b0, bus.invaders_x} + 11'(rm) * 11'(PITCH) + 11'(INVADER_W);
    assign can_right  = (right_edge + 11'(STEP_X)) <= 11'(SCREEN_W);
    assign can_left   = left_edge >= 11'(STEP_X);
    assign y_desc     = bus.invaders_y + 10'(STEP_Y);

    always_comb begin
        state_nx     = state;
        frame_cnt_nx = frame_cnt;
        kills_nx     = kills;
        x_nx         = bus.invaders_x;
        y_nx         = bus.invaders_y;
        alive_nx     = bus.alive;
        kill_nx      = 1'b0;
        kill_num_nx  = '0;
        step_nx      = 1'b0;
        anim_nx      = bus.anim;
        cleared_nx   = bus.cleared;
        landed_nx    = bus.landed;
        descend      = 1'b0;

        if (bus.restart) begin
            state_nx     = MARCH_R;
            frame_cnt_nx = '0;
            kills_nx     = '0;
            x_nx         = 10'(START_X);
            y_nx         = 10'(START_Y);
            alive_nx     = 6'b111111;
            anim_nx      = 1'b0;
            cleared_nx   = 1'b0;
            landed_nx    = 1'b0;
        end else if (state == MARCH_R || state == MARCH_L) begin
            if (hits != 6'b0) begin
                alive_nx    = bus.alive & ~hits;
                kills_nx    = kills + hit_cnt;
                kill_nx     = 1'b1;
                kill_num_nx = hit_cnt;
            end
            // A clearing hit wins over any step due in the same cycle.
            if ((bus.alive & ~hits) == 6'b0) begin
                state_nx   = DONE_CLR;
                cleared_nx = 1'b1;
            end else if (bus.frame) begin
                if (step_due) begin
                    frame_cnt_nx = '0;
                    step_nx      = 1'b1;
                    anim_nx      = ~bus.anim;
                    if (state == MARCH_R) begin
                        if (can_right) x_nx = bus.invaders_x + 10'(STEP_X);
                        else           descend = 1'b1;
                    end else begin
                        if (can_left)  x_nx = bus.invaders_x - 10'(STEP_X);
                        else           descend = 1'b1;
                    end
                    if (descend) begin
                        y_nx = y_desc;
                        if (y_desc >= 10'(BOTTOM_Y)) begin
                            state_nx  = DONE_LAND;
                            landed_nx = 1'b1;
                        end else begin
                            state_nx = (state == MARCH_R) ? MARCH_L : MARCH_R;
                        end
                    end
                end else begin
                    frame_cnt_nx = frame_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= MARCH_R;
            frame_cnt        <= '0;
            kills            <= '0;
            bus.invaders_x   <= 10'(START_X);
            bus.invaders_y   <= 10'(START_Y);
            bus.alive        <= 6'b111111;
            bus.kill         <= 1'b0;
            bus.kill_num     <= '0;
            bus.step         <= 1'b0;
            bus.anim         <= 1'b0;
            bus.cleared      <= 1'b0;
            bus.landed       <= 1'b0;
        end else begin
            state            <= state_nx;
            frame_cnt        <= frame_cnt_nx;
            kills            <= kills_nx;
            bus.invaders_x   <= x_nx;
            bus.invaders_y   <= y_nx;
            bus.alive        <= alive_nx;
            bus.kill         <= kill_nx;
            bus.kill_num     <= kill_num_nx;
            bus.step         <= step_nx;
            bus.anim         <= anim_nx;
            bus.cleared      <= cleared_nx;
            bus.landed       <= landed_nx;
        end
    end

endmodule

// File: tb/tb_invader_fleet_controller.sv
// Scoreboard bench for invader_fleet_controller: three instances (default pacing, fast pacing,
// low start height) driven by directed vectors, with step/kill events checked by a monitor.
module tb_invader_fleet_controller;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] alive;
        logic       kill;
        logic [2:0] kill_num;
        logic       step;
        logic       anim;
        logic       cleared;
        logic       landed;
    } obs_t;

    logic       clk;
    logic       rst_s     [3];
    logic       frame_s   [3];
    logic [5:0] coll_s    [3];
    logic       restart_s [3];
    obs_t       obs       [3];
    obs_t       sb        [3][$];
    obs_t       mon_e;

    int total;
    int bad;

    invader_fleet_controller_if if0 ();
    invader_fleet_controller_if if1 ();
    invader_fleet_controller_if if2 ();

    assign if0.frame = frame_s[0];  assign if0.invader_collision = coll_s[0];  assign if0.restart = restart_s[0];
    assign if1.frame = frame_s[1];  assign if1.invader_collision = coll_s[1];  assign if1.restart = restart_s[1];
    assign if2.frame = frame_s[2];  assign if2.invader_collision = coll_s[2];  assign if2.restart = restart_s[2];

    assign obs[0] = {if0.invaders_x, if0.invaders_y, if0.alive, if0.kill, if0.kill_num, if0.step, if0.anim, if0.cleared, if0.landed};
    assign obs[1] = {if1.invaders_x, if1.invaders_y, if1.alive, if1.kill, if1.kill_num, if1.step, if1.anim, if1.cleared, if1.landed};
    assign obs[2] = {if2.invaders_x, if2.invaders_y, if2.alive, if2.kill, if2.kill_num, if2.step, if2.anim, if2.cleared, if2.landed};

    invader_fleet_controller dut0 (.clk(clk), .rst(rst_s[0]), .bus(if0));
    invader_fleet_controller #(.BASE_PERIOD(1), .MIN_PERIOD(1)) dut1 (.clk(clk), .rst(rst_s[1]), .bus(if1));
    invader_fleet_controller #(.START_Y(384), .BASE_PERIOD(1), .MIN_PERIOD(1)) dut2 (.clk(clk), .rst(rst_s[2]), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t ev(int x, int y, logic [5:0] al, logic kl, int kn, logic st, logic an, logic clr, logic lnd);
        obs_t e;
        e.x = 10'(x); e.y = 10'(y); e.alive = al; e.kill = kl; e.kill_num = 3'(kn);
        e.step = st; e.anim = an; e.cleared = clr; e.landed = lnd;
        return e;
    endfunction

    // Any step or kill pulse must match the oldest expectation queued for that instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_s[i] && (obs[i].step || obs[i].kill)) begin
                total++;
                if (sb[i].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event dut%0d got x=%0d y=%0d alive=%b kill=%b kn=%0d step=%b anim=%b clr=%b land=%b exp none",
                             i, obs[i].x, obs[i].y, obs[i].alive, obs[i].kill, obs[i].kill_num, obs[i].step, obs[i].anim, obs[i].cleared, obs[i].landed);
                end else begin
                    mon_e = sb[i].pop_front();
                    if (obs[i] !== mon_e) begin
                        bad++;
                        $display("FAIL event dut%0d got x=%0d y=%0d alive=%b kill=%b kn=%0d step=%b anim=%b clr=%b land=%b exp x=%0d y=%0d alive=%b kill=%b kn=%0d step=%b anim=%b clr=%b land=%b",
                                 i, obs[i].x, obs[i].y, obs[i].alive, obs[i].kill, obs[i].kill_num, obs[i].step, obs[i].anim, obs[i].cleared, obs[i].landed,
                                 mon_e.x, mon_e.y, mon_e.alive, mon_e.kill, mon_e.kill_num, mon_e.step, mon_e.anim, mon_e.cleared, mon_e.landed);
                    end
                end
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int id, logic frm, logic [5:0] c);
        @(negedge clk);
        frame_s[id] = frm;
        coll_s[id]  = c;
        @(negedge clk);
        frame_s[id] = 1'b0;
        coll_s[id]  = '0;
    endtask

    task automatic frames(int id, int n);
        repeat (n) cyc(id, 1'b1, 6'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; frame_s[i] = 1'b0; coll_s[i] = '0; restart_s[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;

        // Reset state
        chk("rst_x", int'(obs[0].x), 64);
        chk("rst_y", int'(obs[0].y), 48);
        chk("rst_alive", int'(obs[0].alive), 63);
        chk("rst_flags", int'({obs[0].kill, obs[0].kill_num, obs[0].step, obs[0].anim, obs[0].cleared, obs[0].landed}), 0);

        // Default pacing: step on the 30th frame
        frames(0, 29);
        chk("pace29_x", int'(obs[0].x), 64);
        sb[0].push_back(ev(68, 48, 6'b111111, 0, 0, 1, 1, 0, 0));
        cyc(0, 1'b1, 6'b0);
        @(negedge clk);
        chk("step_one_cycle", int'(obs[0].step), 0);

        // Double kill, then period shortens to 22
        sb[0].push_back(ev(68, 48, 6'b011110, 1, 2, 0, 1, 0, 0));
        cyc(0, 1'b0, 6'b100001);
        frames(0, 21);
        chk("period22_hold_x", int'(obs[0].x), 68);
        sb[0].push_back(ev(72, 48, 6'b011110, 0, 0, 1, 0, 0, 0));
        cyc(0, 1'b1, 6'b0);

        // Dead-column hit is ignored
        cyc(0, 1'b0, 6'b000001);
        chk("dead_hit_alive", int'(obs[0].alive), 6'b011110);

        // Kill the rest; the final hit lands on the step frame (period 10 at five kills)
        sb[0].push_back(ev(72, 48, 6'b011100, 1, 1, 0, 0, 0, 0));
        cyc(0, 1'b0, 6'b000010);
        sb[0].push_back(ev(72, 48, 6'b010000, 1, 2, 0, 0, 0, 0));
        cyc(0, 1'b0, 6'b001100);
        frames(0, 9);
        sb[0].push_back(ev(72, 48, 6'b000000, 1, 1, 0, 0, 1, 0));
        cyc(0, 1'b1, 6'b010000);
        chk("cleared", int'(obs[0].cleared), 1);
        frames(0, 3);
        cyc(0, 1'b0, 6'b111111);
        chk("clr_hold_x", int'(obs[0].x), 72);

        // Restart re-arms the wave and zeroes kills
        @(negedge clk); restart_s[0] = 1'b1;
        @(negedge clk); restart_s[0] = 1'b0;
        chk("restart_x", int'(obs[0].x), 64);
        chk("restart_y", int'(obs[0].y), 48);
        chk("restart_alive", int'(obs[0].alive), 63);
        chk("restart_flags", int'({obs[0].cleared, obs[0].anim}), 0);
        frames(0, 29);
        sb[0].push_back(ev(68, 48, 6'b111111, 0, 0, 1, 1, 0, 0));
        cyc(0, 1'b1, 6'b0);

        // Fast pacing: right edge, descend, march left to x=0, descend again
        for (int i = 1; i <= 76; i++) begin
            sb[1].push_back(ev(64 + 4 * i, 48, 6'b111111, 0, 0, 1, 1'(i % 2), 0, 0));
            cyc(1, 1'b1, 6'b0);
        end
        chk("right_edge_x", int'(obs[1].x), 368);
        sb[1].push_back(ev(368, 64, 6'b111111, 0, 0, 1, 1, 0, 0));
        cyc(1, 1'b1, 6'b0);
        sb[1].push_back(ev(364, 64, 6'b111111, 0, 0, 1, 0, 0, 0));
        cyc(1, 1'b1, 6'b0);
        for (int j = 1; j <= 91; j++) begin
            sb[1].push_back(ev(364 - 4 * j, 64, 6'b111111, 0, 0, 1, 1'(j % 2), 0, 0));
            cyc(1, 1'b1, 6'b0);
        end
        sb[1].push_back(ev(0, 80, 6'b111111, 0, 0, 1, 0, 0, 0));
        cyc(1, 1'b1, 6'b0);
        sb[1].push_back(ev(4, 80, 6'b111111, 0, 0, 1, 1, 0, 0));
        cyc(1, 1'b1, 6'b0);

        // Landing: descend from 384 reaches 400
        for (int i = 1; i <= 76; i++) begin
            sb[2].push_back(ev(64 + 4 * i, 384, 6'b111111, 0, 0, 1, 1'(i % 2), 0, 0));
            cyc(2, 1'b1, 6'b0);
        end
        sb[2].push_back(ev(368, 400, 6'b111111, 0, 0, 1, 1, 0, 1));
        cyc(2, 1'b1, 6'b0);
        chk("landed", int'(obs[2].landed), 1);
        frames(2, 3);
        cyc(2, 1'b0, 6'b111111);
        chk("land_hold_alive", int'(obs[2].alive), 63);
        chk("land_hold_x", int'(obs[2].x), 368);

        // rst wins over a simultaneous restart and clears landed
        @(negedge clk); rst_s[2] = 1'b1; restart_s[2] = 1'b1;
        @(negedge clk);
        @(negedge clk); rst_s[2] = 1'b0; restart_s[2] = 1'b0;
        chk("rst_landed", int'(obs[2].landed), 0);
        chk("rst_land_y", int'(obs[2].y), 384);
        chk("rst_land_x", int'(obs[2].x), 64);

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (sb[i].size() != 0) begin
                bad++;
                $display("FAIL missing_events dut%0d got=%0d pending exp=0", i, sb[i].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
